// File: rtl/edge_event_arbiter.sv
// Rising-edge event detector with round-robin arbitration onto a
// single valid/ready event stream, plus sticky per-channel overflow flags.
module edge_event_arbiter #(
  parameter int N_CH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           sig,
  output logic                      event_valid,
  output logic [$clog2(N_CH)-1:0]   event_id,
  input  logic                      event_ready,
  output logic [N_CH-1:0]           pending,
  output logic [N_CH-1:0]           overflow,
  input  logic                      ovf_clear
);

  localparam int IW = $clog2(N_CH);

  logic [N_CH-1:0] sig_q;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [N_CH-1:0] rise, grant_mask, ovf_set;
  logic            valid_q, valid_d;
  logic [IW-1:0]   id_q, id_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   win;
  logic            found, free;
  logic [IW:0]     cand;

  // Search upward from last_id+1, wrapping; cand is one bit wider
  // so last_id+k never truncates before the wrap subtraction.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = {1'b0, last_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_CH))
        cand = cand - (IW+1)'(N_CH);
      if (!found && pending_q[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    free       = ~valid_q | event_ready;
    rise       = sig & ~sig_q;
    grant_mask = '0;
    if (free && found)
      grant_mask[win] = 1'b1;
    // A rise onto a bit being granted this edge is a fresh event, not a loss.
    ovf_set   = rise & pending_q & ~grant_mask;
    ovf_d     = (ovf_clear ? '0 : ovf_q) | ovf_set;
    pending_d = (pending_q & ~grant_mask) | rise;
    valid_d   = valid_q;
    id_d      = id_q;
    last_d    = last_q;
    if (free) begin
      valid_d = found;
      if (found) begin
        id_d   = win;
        last_d = win;
      end
    end
  end

  // sig_q resets high so a level already high at release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q     <= '1;
      pending_q <= '0;
      ovf_q     <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      last_q    <= IW'(N_CH - 1);
    end else begin
      sig_q     <= sig;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      last_q    <= last_d;
    end
  end

  assign event_valid = valid_q;
  assign event_id    = id_q;
  assign pending     = pending_q;
  assign overflow    = ovf_q;

endmodule
